// File: rtl/stack_pkg.sv
// Shared defaults and FSM encoding for the stack controller.
package stack_pkg;
  localparam int STK_DEPTH = 1024;
  localparam int STK_AW    = 10;
  localparam int STK_DW    = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM: one-cycle synchronous read, write when wea, no output register.
module stack_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic [AW-1:0] addra,
  input  logic          cea,
  input  logic          wea,
  input  logic [DW-1:0] dia,
  output logic [DW-1:0] doa
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_doa;

  always_ff @(posedge clk) begin
    if (cea) begin
      if (wea) r_mem[addra] <= dia;
      else     r_doa        <= r_mem[addra];
    end
  end

  assign doa = r_doa;
endmodule

// File: rtl/stack_ctrl.sv
// LIFO controller over an external single-port RAM; 3-cycle pop, 1-cycle push.
// Optional sticky overflow/underflow flags are built when STACK_CTRL_ERR_EN is defined.
import stack_pkg::*;

module stack_ctrl #(
  parameter int DEPTH = STK_DEPTH,
  parameter int AW    = STK_AW,
  parameter int DW    = STK_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_valid,
  output logic          pop_ready,
  output logic          pop_dvalid,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] ram_addr,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic          ovf_err,
  output logic          unf_err
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t        r_state;
  logic [AW:0]   r_sp;
  logic          r_clr_pend;
  logic          r_dvalid;
  logic [DW-1:0] r_pop_data;
  logic [AW-1:0] r_addr;
  logic          r_ce;
  logic          r_we;
  logic [DW-1:0] r_di;

  logic          w_idle;
  logic          w_empty;
  logic          w_full;
  logic          w_push_acc;
  logic          w_pop_acc;
  logic [AW:0]   w_sp_dec;

  assign w_idle     = (r_state == IDLE);
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == FULL_LVL);
  assign push_ready = w_idle & ~w_full & ~pop_valid & ~clear;
  assign pop_ready  = w_idle & ~w_empty & ~clear;
  assign w_push_acc = push_valid & push_ready;
  assign w_pop_acc  = pop_valid & pop_ready;
  assign w_sp_dec   = r_sp - ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sp       <= '0;
      r_clr_pend <= 1'b0;
      r_dvalid   <= 1'b0;
      r_pop_data <= '0;
      r_addr     <= '0;
      r_ce       <= 1'b0;
      r_we       <= 1'b0;
      r_di       <= '0;
    end else begin
      r_ce     <= 1'b0;
      r_we     <= 1'b0;
      r_di     <= '0;
      r_dvalid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (clear) begin
            r_sp <= '0;
          end else if (w_pop_acc) begin
            // Read address is the post-decrement pointer: the top entry.
            r_sp    <= w_sp_dec;
            r_ce    <= 1'b1;
            r_addr  <= w_sp_dec[AW-1:0];
            r_state <= RD_ISSUE;
          end else if (w_push_acc) begin
            r_sp   <= r_sp + ONE;
            r_ce   <= 1'b1;
            r_we   <= 1'b1;
            r_addr <= r_sp[AW-1:0];
            r_di   <= push_data;
          end
        end
        RD_ISSUE: begin
          if (clear) r_clr_pend <= 1'b1;
          r_state <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          // A flush seen mid-read is applied only once the word is delivered.
          r_pop_data <= ram_do;
          r_dvalid   <= 1'b1;
          r_clr_pend <= 1'b0;
          if (clear | r_clr_pend) r_sp <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign level      = r_sp;
  assign empty      = w_empty;
  assign full       = w_full;
  assign pop_dvalid = r_dvalid;
  assign pop_data   = r_pop_data;
  assign ram_addr   = r_addr;
  assign ram_ce     = r_ce;
  assign ram_we     = r_we;
  assign ram_di     = r_di;

`ifdef STACK_CTRL_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_idle) begin
      if (push_valid & w_full)  r_ovf <= 1'b1;
      if (pop_valid  & w_empty) r_unf <= 1'b1;
    end
  end

  assign ovf_err = r_ovf;
  assign unf_err = r_unf;
`else
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
`endif
endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: a queue-based stack model predicts every output,
// and a scoreboard matches each pop_dvalid against the word and cycle recorded at acceptance.
module tb_stack_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          push_valid = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid = 1'b0;
  logic          push_ready, pop_ready, pop_dvalid, empty, full;
  logic [DW-1:0] pop_data, ram_di, ram_do;
  logic [AW:0]   level;
  logic [AW-1:0] ram_addr;
  logic          ram_ce, ram_we, ovf_err, unf_err;

  always #5 clk = ~clk;

  stack_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_dvalid(pop_dvalid),
    .pop_data(pop_data), .level(level), .empty(empty), .full(full),
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we), .ram_di(ram_di),
    .ram_do(ram_do), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  stack_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk(clk), .addra(ram_addr), .cea(ram_ce), .wea(ram_we), .dia(ram_di), .doa(ram_do)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } sb_t;

  // Reference model state
  logic [DW-1:0] stk[$];
  sb_t           expq[$];
  int            busy = 0;
  bit            clrp = 0;
  bit            started = 0;
  int            cyc = 0;
  logic [DW-1:0] rd_word = '0;
  logic          e_ce = 0, e_we = 0, e_dv = 0, e_ovf = 0, e_unf = 0;
  logic [DW-1:0] e_di = '0, e_pd = '0;
  logic [AW-1:0] e_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were stable at that edge.
  task automatic model_update();
    bit was_full, was_empty;
    was_full  = (stk.size() == DEPTH);
    was_empty = (stk.size() == 0);
    e_ce = 0; e_we = 0; e_di = '0; e_dv = 0;
    if (!rst_n) begin
      stk.delete(); expq.delete();
      busy = 0; clrp = 0; e_pd = '0; e_addr = '0; e_ovf = 0; e_unf = 0;
    end else if (busy != 0) begin
      if (clear) begin clrp = 1; e_ovf = 0; e_unf = 0; end
      if (busy == 1) begin
        e_dv = 1; e_pd = rd_word;
        if (clrp) stk.delete();
        clrp = 0;
      end
      busy--;
    end else if (clear) begin
      stk.delete(); e_ovf = 0; e_unf = 0;
    end else begin
      if (pop_valid && !was_empty) begin
        rd_word = stk.pop_back();
        busy = 2; e_ce = 1; e_addr = AW'(stk.size());
        expq.push_back('{due: cyc + 3, data: rd_word});
      end else if (push_valid && !pop_valid && !was_full) begin
        e_ce = 1; e_we = 1; e_addr = AW'(stk.size()); e_di = push_data;
        stk.push_back(push_data);
      end
`ifdef STACK_CTRL_ERR_EN
      if (push_valid && was_full)  e_ovf = 1;
      if (pop_valid  && was_empty) e_unf = 1;
`endif
    end
    cyc++;
    started = 1;
  endtask

  task automatic drive(input logic r, input logic c, input logic pv, input logic [DW-1:0] d,
                       input logic ppv);
    rst_n = r; clear = c; push_valid = pv; push_data = d; pop_valid = ppv;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle output check plus scoreboard pop on each pop_dvalid.
  initial forever begin
    @(negedge clk);
    if (started) begin
      bit idle;
      idle = (busy == 0);
      chk("level", 32'(level), 32'(stk.size()));
      chk("empty", 32'(empty), 32'(stk.size() == 0));
      chk("full",  32'(full),  32'(stk.size() == DEPTH));
      chk("push_ready", 32'(push_ready),
          32'(idle && stk.size() < DEPTH && !pop_valid && !clear));
      chk("pop_ready", 32'(pop_ready), 32'(idle && stk.size() > 0 && !clear));
      chk("pop_dvalid", 32'(pop_dvalid), 32'(e_dv));
      chk("pop_data", 32'(pop_data), 32'(e_pd));
      chk("ram_ce", 32'(ram_ce), 32'(e_ce));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_di", 32'(ram_di), 32'(e_di));
      chk("ovf_err", 32'(ovf_err), 32'(e_ovf));
      chk("unf_err", 32'(unf_err), 32'(e_unf));
      if (pop_dvalid === 1'b1) begin
        if (expq.size() == 0) begin
          chk("sb_unexpected_dvalid", 32'(1), 32'(0));
        end else begin
          sb_t ent;
          ent = expq.pop_front();
          chk("sb_latency", 32'(cyc), 32'(ent.due));
          chk("sb_data", 32'(pop_data), 32'(ent.data));
        end
      end
    end
  end

  initial begin
    // Reset, then three back-to-back pushes
    repeat (3) drive(0, 0, 0, '0, 0);
    drive(1, 0, 1, 4'h3, 0);
    drive(1, 0, 1, 4'h7, 0);
    drive(1, 0, 1, 4'hA, 0);
    drive(1, 0, 0, '0, 0);
    // Three pops with pop_valid held; ends with pop_valid on an empty stack
    repeat (11) drive(1, 0, 0, '0, 1);
    drive(1, 0, 0, '0, 0);
    // Same-cycle push and pop at level 2: pop wins, push lands 3 cycles later
    drive(1, 1, 0, '0, 0);
    drive(1, 0, 1, 4'h5, 0);
    drive(1, 0, 1, 4'hC, 0);
    drive(1, 0, 1, 4'h9, 1);
    repeat (3) drive(1, 0, 1, 4'h9, 0);
    drive(1, 0, 0, '0, 0);
    // Clear while the read is in RD_ISSUE
    drive(1, 0, 0, '0, 1);
    drive(1, 1, 0, '0, 0);
    repeat (4) drive(1, 0, 0, '0, 0);
    // Fill to full and push past it
    drive(1, 1, 0, '0, 0);
    repeat (DEPTH + 6) drive(1, 0, 1, DW'($urandom), 0);
    drive(1, 0, 0, '0, 1);
    repeat (3) drive(1, 0, 0, '0, 0);
    // Random traffic
    repeat (3000)
      drive(1, ($urandom % 40) == 0, $urandom_range(0, 1) == 1, DW'($urandom),
            ($urandom % 3) == 0);
    // Reset in the middle of a read abandons it
    drive(1, 1, 0, '0, 0);
    drive(1, 0, 1, 4'h6, 0);
    drive(1, 0, 0, '0, 1);
    repeat (2) drive(0, 0, 0, '0, 0);
    repeat (5) drive(1, 0, 0, '0, 0);
    chk("sb_outstanding", 32'(expq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
